// File: rtl/vector_change_monitor.sv
// rtl/vector_change_monitor.sv - per-bit change detector with rising-edge counters and 2-entry event FIFO
// Define VEC_MON_SAT_EN to make the counters saturate instead of wrap.
module vector_change_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sample_en,
  input  logic [2:0]       in_vec,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_vec,
  output logic [2:0]       evt_chg,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt0,
  output logic             ovf
);

  logic [2:0]       prev;
  logic             primed;
  logic [CNT_W-1:0] cnt_q [3];
  logic [5:0]       ent_q [2];
  logic [5:0]       ent_d [2];
  logic [1:0]       occ_q, occ_d;
  logic             ovf_d;
  logic [2:0]       chg;
  logic [2:0]       rise;
  logic             pop;
  logic             push;

  assign chg  = in_vec ^ prev;
  assign rise = in_vec & ~prev;
  assign pop  = evt_valid && evt_ready;
  assign push = sample_en && primed && (chg != 3'b000);

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc);
`ifdef VEC_MON_SAT_EN
    return (inc && (c != {CNT_W{1'b1}})) ? c + CNT_W'(1) : c;
`else
    return inc ? c + CNT_W'(1) : c;
`endif
  endfunction

  // Pop is applied first, so a push into a full FIFO succeeds whenever the head leaves.
  always_comb begin
    ent_d = ent_q;
    occ_d = occ_q;
    ovf_d = ovf;
    if (pop) begin
      ent_d[0] = ent_q[1];
      occ_d    = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd2) begin
        ovf_d = 1'b1;
      end else begin
        ent_d[occ_d[0]] = {in_vec, chg};
        occ_d           = occ_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev   <= 3'b000;
      primed <= 1'b0;
      cnt_q  <= '{default: '0};
      ent_q  <= '{default: '0};
      occ_q  <= 2'd0;
      ovf    <= 1'b0;
    end else if (clr) begin
      prev   <= 3'b000;
      primed <= 1'b0;
      cnt_q  <= '{default: '0};
      ent_q  <= '{default: '0};
      occ_q  <= 2'd0;
      ovf    <= 1'b0;
    end else begin
      ent_q <= ent_d;
      occ_q <= occ_d;
      ovf   <= ovf_d;
      if (sample_en) begin
        prev   <= in_vec;
        primed <= 1'b1;
        if (primed) begin
          for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= bump(cnt_q[i], rise[i]);
          end
        end
      end
    end
  end

  assign evt_valid = (occ_q != 2'd0);
  assign evt_vec   = ent_q[0][5:3];
  assign evt_chg   = ent_q[0][2:0];
  assign cnt0      = cnt_q[0];
  assign cnt1      = cnt_q[1];
  assign cnt2      = cnt_q[2];

endmodule

// File: tb/tb_vector_change_monitor.sv
// tb/tb_vector_change_monitor.sv - self-checking bench for vector_change_monitor
module tb_vector_change_monitor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, clr, sample_en, evt_ready;
  logic [2:0]   in_vec;
  logic         evt_valid, ovf;
  logic [2:0]   evt_vec, evt_chg;
  logic [W-1:0] cnt0, cnt1, cnt2;

  logic         s_clr, s_sen, s_rdy, s_valid, s_ovf;
  logic [2:0]   s_vec, s_evec, s_echg;
  logic [1:0]   s_c0, s_c1, s_c2;

  int checks = 0;
  int failures = 0;

  vector_change_monitor #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .sample_en(sample_en), .in_vec(in_vec),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_vec(evt_vec), .evt_chg(evt_chg),
    .cnt2(cnt2), .cnt1(cnt1), .cnt0(cnt0), .ovf(ovf)
  );

  vector_change_monitor #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .clr(s_clr), .sample_en(s_sen), .in_vec(s_vec),
    .evt_valid(s_valid), .evt_ready(s_rdy), .evt_vec(s_evec), .evt_chg(s_echg),
    .cnt2(s_c2), .cnt1(s_c1), .cnt0(s_c0), .ovf(s_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, sen;
    logic [2:0] vec;
    logic       rdy;
    logic       ev;
    logic [2:0] ev_vec, ev_chg;
    int         c0, c1, c2;
    logic       ov;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(input logic c, input logic s, input logic [2:0] v, input logic r,
                              input logic ev, input logic [2:0] ev_vec, input logic [2:0] ev_chg,
                              input int c0, input int c1, input int c2, input logic ov);
    row_t x;
    x.clr = c; x.sen = s; x.vec = v; x.rdy = r; x.ev = ev; x.ev_vec = ev_vec; x.ev_chg = ev_chg;
    x.c0 = c0; x.c1 = c1; x.c2 = c2; x.ov = ov;
    return x;
  endfunction

  // Reference model: event queue capped at two entries, plain integer counters.
  bit [2:0] m_prev;
  bit       m_primed;
  int       m_cnt[3];
  bit       m_ovf;
  bit [5:0] m_q[$];

  function automatic void m_clear();
    m_prev = 0; m_primed = 0; m_ovf = 0; m_q.delete();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endfunction

  function automatic void m_step(input bit c, input bit s, input bit [2:0] v, input bit r);
    int maxv;
    maxv = (1 << W) - 1;
    if (c) begin
      m_clear();
      return;
    end
    if (m_q.size() > 0 && r) void'(m_q.pop_front());
    if (s && m_primed && v != m_prev) begin
      if (m_q.size() < 2) m_q.push_back({v, v ^ m_prev});
      else m_ovf = 1;
    end
    if (s && m_primed) begin
      for (int i = 0; i < 3; i++) begin
        if (!m_prev[i] && v[i]) begin
`ifdef VEC_MON_SAT_EN
          if (m_cnt[i] < maxv) m_cnt[i] = m_cnt[i] + 1;
`else
          m_cnt[i] = (m_cnt[i] + 1) % (maxv + 1);
`endif
        end
      end
    end
    if (s) begin
      m_prev = v;
      m_primed = 1;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic s, input logic [2:0] v, input logic r);
    clr = c; sample_en = s; in_vec = v; evt_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"}, int'(evt_valid), 0);
    chk({tag, "_cnt0"}, int'(cnt0), 0);
    chk({tag, "_cnt1"}, int'(cnt1), 0);
    chk({tag, "_cnt2"}, int'(cnt2), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
  endtask

  // Baseline at 0, then five 0->1 toggles on bit 0 with no consumer: FIFO full, cnt0=5.
  task automatic fill_five();
    cyc(1, 0, 3'd0, 0);
    cyc(0, 1, 3'd0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 3'd1, 0);
      cyc(0, 1, 3'd0, 0);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 0; sample_en = 0; in_vec = 0; evt_ready = 0;
    s_clr = 0; s_sen = 0; s_vec = 0; s_rdy = 1;
    #12;
    chk("reset_valid", int'(evt_valid), 0);
    chk("reset_vec", int'(evt_vec), 0);
    chk("reset_chg", int'(evt_chg), 0);
    chk("reset_cnts", int'(cnt0) + int'(cnt1) + int'(cnt2), 0);
    chk("reset_ovf", int'(ovf), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // baseline then first change
    tbl.push_back(mk(0, 1, 3'b101, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b110, 1, 1, 3'b110, 3'b011, 0, 1, 0, 0));
    // sweep 0..7
    tbl.push_back(mk(1, 0, 3'b000, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd1, 1, 1, 3'd1, 3'b001, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd2, 1, 1, 3'd2, 3'b011, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'd3, 1, 1, 3'd3, 3'b001, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'd4, 1, 1, 3'd4, 3'b111, 2, 1, 1, 0));
    tbl.push_back(mk(0, 1, 3'd5, 1, 1, 3'd5, 3'b001, 3, 1, 1, 0));
    tbl.push_back(mk(0, 1, 3'd6, 1, 1, 3'd6, 3'b011, 3, 2, 1, 0));
    tbl.push_back(mk(0, 1, 3'd7, 1, 1, 3'd7, 3'b001, 4, 2, 1, 0));
    tbl.push_back(mk(0, 0, 3'd0, 1, 0, 0, 0, 4, 2, 1, 0));
    // backpressure and overflow
    tbl.push_back(mk(1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd1, 0, 1, 3'd1, 3'b001, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd2, 0, 1, 3'd1, 3'b001, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'd3, 0, 1, 3'd1, 3'b001, 2, 1, 0, 1));
    tbl.push_back(mk(0, 0, 3'd3, 0, 1, 3'd1, 3'b001, 2, 1, 0, 1));
    tbl.push_back(mk(0, 0, 3'd3, 1, 1, 3'd2, 3'b011, 2, 1, 0, 1));
    tbl.push_back(mk(0, 0, 3'd3, 1, 0, 0, 0, 2, 1, 0, 1));
    tbl.push_back(mk(0, 0, 3'd3, 1, 0, 0, 0, 2, 1, 0, 1));
    // full with simultaneous pop
    tbl.push_back(mk(1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd1, 0, 1, 3'd1, 3'b001, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd2, 0, 1, 3'd1, 3'b001, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'd3, 1, 1, 3'd2, 3'b011, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 3'd3, 1, 1, 3'd3, 3'b001, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 3'd3, 1, 0, 0, 0, 2, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].clr, tbl[i].sen, tbl[i].vec, tbl[i].rdy);
      chk($sformatf("row%0d_valid", i), int'(evt_valid), int'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("row%0d_vec", i), int'(evt_vec), int'(tbl[i].ev_vec));
        chk($sformatf("row%0d_chg", i), int'(evt_chg), int'(tbl[i].ev_chg));
      end
      chk($sformatf("row%0d_cnt0", i), int'(cnt0), tbl[i].c0);
      chk($sformatf("row%0d_cnt1", i), int'(cnt1), tbl[i].c1);
      chk($sformatf("row%0d_cnt2", i), int'(cnt2), tbl[i].c2);
      chk($sformatf("row%0d_ovf", i), int'(ovf), int'(tbl[i].ov));
    end

    // clr with a full FIFO and cnt0=5, then the next sample must be a baseline
    fill_five();
    chk("fill_cnt0", int'(cnt0), 5);
    chk("fill_valid", int'(evt_valid), 1);
    chk("fill_ovf", int'(ovf), 1);
    cyc(1, 1, 3'd1, 1);
    check_cleared("clr");
    cyc(0, 1, 3'd1, 1);
    check_cleared("clr_baseline");
    cyc(0, 1, 3'd0, 1);
    chk("clr_after_valid", int'(evt_valid), 1);
    chk("clr_after_chg", int'(evt_chg), 1);

    // asynchronous reset pulsed between edges
    fill_five();
    chk("fill2_cnt0", int'(cnt0), 5);
    #2 rst = 1'b1;
    #1;
    check_cleared("rst_async");
    rst = 1'b0;
    cyc(0, 1, 3'd1, 1);
    check_cleared("rst_baseline");
    cyc(0, 1, 3'd3, 1);
    chk("rst_after_valid", int'(evt_valid), 1);
    chk("rst_after_vec", int'(evt_vec), 3);
    chk("rst_after_cnt1", int'(cnt1), 1);

    // narrow counters: five rising edges on bit 0
    s_sen = 1; s_vec = 3'd0;
    @(posedge clk); #1;
    for (int k = 0; k < 9; k++) begin
      s_vec = (k % 2 == 0) ? 3'd1 : 3'd0;
      @(posedge clk); #1;
    end
    s_sen = 0;
`ifdef VEC_MON_SAT_EN
    chk("small_cnt0_sat", int'(s_c0), 3);
`else
    chk("small_cnt0_wrap", int'(s_c0), 1);
`endif
    chk("small_ovf", int'(s_ovf), 0);

    // randomized run against the model
    cyc(1, 0, 3'd0, 0);
    m_clear();
    for (int n = 0; n < 1500; n++) begin
      logic c, s, r;
      logic [2:0] v;
      c = ($urandom_range(0, 63) == 0);
      s = ($urandom_range(0, 3) != 0);
      v = 3'($urandom_range(0, 7));
      r = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      m_step(c, s, v, r);
      cyc(c, s, v, r);
      chk("rnd_valid", int'(evt_valid), int'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("rnd_vec", int'(evt_vec), int'(m_q[0][5:3]));
        chk("rnd_chg", int'(evt_chg), int'(m_q[0][2:0]));
      end
      chk("rnd_cnt0", int'(cnt0), m_cnt[0]);
      chk("rnd_cnt1", int'(cnt1), m_cnt[1]);
      chk("rnd_cnt2", int'(cnt2), m_cnt[2]);
      chk("rnd_ovf", int'(ovf), int'(m_ovf));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
